// File: rtl/mips_pkg.sv
// Constants shared by the fetch stage and the control decoder.
// Holds the next-PC select encoding, the default reset PC and a sign-extend helper.
package mips_pkg;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_J   = 2'b01;
  localparam logic [1:0] NPC_BR  = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/npc.sv
// Next-PC selection, purely combinational, driven by the instruction currently in D.
// Branch target is relative to the delay slot (PC_D+4); jr target is taken verbatim.
module npc
  import mips_pkg::*;
(
  input  logic [31:0] PC_F,
  input  logic [31:0] PC_D,
  input  logic [31:0] Instr_D,
  input  logic [1:0]  NPCop,
  input  logic        Judge,
  input  logic [31:0] RS_D,
  output logic [31:0] NPC
);

  logic [31:0] pc_f4;
  logic [31:0] pc_d4;
  logic [31:0] br_off;
  logic        unused_instr_hi;

  assign pc_f4  = PC_F + 32'd4;
  assign pc_d4  = PC_D + 32'd4;
  assign br_off = sext16(Instr_D[15:0]) << 2;

  // Opcode bits are decoded elsewhere; only the immediate/index fields matter here.
  assign unused_instr_hi = ^Instr_D[31:26];

  always_comb begin
    NPC = pc_f4;
    case (NPCop)
      NPC_PC4: NPC = pc_f4;
      NPC_J:   NPC = {pc_d4[31:28], Instr_D[25:0], 2'b00};
      NPC_BR:  NPC = Judge ? (pc_d4 + br_off) : pc_f4;
      NPC_JR:  NPC = RS_D;
      default: NPC = pc_f4;
    endcase
  end

endmodule

// File: rtl/fetch_ifid.sv
// Fetch stage: PC register, next-PC mux and the IF/ID pipeline register.
// One delay slot, no flush; stall freezes PC and IF/ID, reset dominates stall.
module fetch_ifid
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] Instr_F,
  input  logic [1:0]  NPCop,
  input  logic        Judge,
  input  logic [31:0] RS_D,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D
);

  logic [31:0] pc_f_q,    pc_f_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q,    pc_d_d;
  logic [31:0] npc_w;

  npc u_npc (
    .PC_F    (pc_f_q),
    .PC_D    (pc_d_q),
    .Instr_D (instr_d_q),
    .NPCop   (NPCop),
    .Judge   (Judge),
    .RS_D    (RS_D),
    .NPC     (npc_w)
  );

  // A stalled redirect is simply re-evaluated later from the held D-stage state.
  always_comb begin
    pc_f_d    = pc_f_q;
    instr_d_d = instr_d_q;
    pc_d_d    = pc_d_q;
    if (!stall) begin
      pc_f_d    = npc_w;
      instr_d_d = Instr_F;
      pc_d_d    = pc_f_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q    <= PC_RESET;
      instr_d_q <= INSTR_NOP;
      pc_d_q    <= PC_RESET;
    end else begin
      pc_f_q    <= pc_f_d;
      instr_d_q <= instr_d_d;
      pc_d_q    <= pc_d_d;
    end
  end

  assign PC_F    = pc_f_q;
  assign Instr_D = instr_d_q;
  assign PC_D    = pc_d_q;
  assign PC8_D   = pc_d_q + 32'd8;

endmodule

// File: tb/tb_fetch_ifid.sv
// Self-checking bench for fetch_ifid: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch/delay-slot rules.
module tb_fetch_ifid;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] Instr_F;
  logic [1:0]  NPCop;
  logic        Judge;
  logic [31:0] RS_D;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_pcf, m_instr, m_pcd;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] BEQ    = 32'h1085_FFFE;
  localparam logic [31:0] JAL    = 32'h0C00_0C40;
  localparam logic [31:0] JR     = 32'h03E0_0008;

  fetch_ifid #(.PC_RESET(RST_PC)) dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .Instr_F (Instr_F),
    .NPCop   (NPCop),
    .Judge   (Judge),
    .RS_D    (RS_D),
    .PC_F    (PC_F),
    .Instr_D (Instr_D),
    .PC_D    (PC_D),
    .PC8_D   (PC8_D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_target();
    int          off;
    logic [31:0] t;
    case (NPCop)
      2'd1: t = ((m_pcd + 32'd4) & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      2'd2: begin
        off = int'($signed(m_instr[15:0]));
        t = Judge ? (m_pcd + 32'd4 + 32'(off * 4)) : (m_pcf + 32'd4);
      end
      2'd3: t = RS_D;
      default: t = m_pcf + 32'd4;
    endcase
    return t;
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    logic [31:0] t;
    @(posedge clk);
    t = model_target();
    if (reset) begin
      m_pcf = RST_PC; m_instr = 32'h0; m_pcd = RST_PC;
    end else if (!stall) begin
      m_pcd = m_pcf; m_instr = Instr_F; m_pcf = t;
    end
    #1;
    chk("model_pc_f", PC_F, m_pcf);
    chk("model_instr_d", Instr_D, m_instr);
    chk("model_pc_d", PC_D, m_pcd);
    chk("model_pc8_d", PC8_D, m_pcd + 32'd8);
  endtask

  task automatic drive(input logic r, input logic s, input logic [1:0] op,
                       input logic j, input logic [31:0] rs, input logic [31:0] ins);
    reset = r; stall = s; NPCop = op; Judge = j; RS_D = rs; Instr_F = ins;
  endtask

  // Reset, free-run to PC_F=0x3010, then load the beq so it sits in D at 0x3010.
  task automatic beq_at_3010();
    drive(1, 0, 2'd0, 0, 0, 32'h0); step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 2'd0, 0, 0, 32'h1111_0000 + i); step();
    end
    drive(0, 0, 2'd0, 0, 0, BEQ); step();
    chk("beq_pc_d", PC_D, 32'h0000_3010);
  endtask

  logic [31:0] hold_pc, hold_instr;

  initial begin
    drive(1, 0, 2'd0, 0, 0, 32'h0);
    step();
    chk("rst_pc_f", PC_F, 32'h0000_3000);
    chk("rst_instr_d", Instr_D, 32'h0);
    chk("rst_pc_d", PC_D, 32'h0000_3000);
    chk("rst_pc8_d", PC8_D, 32'h0000_3008);

    // Free run
    drive(0, 0, 2'd0, 0, 0, 32'hAAAA_0001); step();
    chk("run1_pc_f", PC_F, 32'h0000_3004);
    chk("run1_instr_d", Instr_D, 32'hAAAA_0001);
    drive(0, 0, 2'd0, 0, 0, 32'hAAAA_0002); step();
    chk("run2_pc_f", PC_F, 32'h0000_3008);
    chk("run2_pc_d", PC_D, 32'h0000_3004);
    drive(0, 0, 2'd0, 0, 0, 32'hAAAA_0003); step();
    chk("run3_pc_f", PC_F, 32'h0000_300C);
    chk("run3_pc8_d", PC8_D, 32'h0000_3010);

    // Branch taken, backwards
    beq_at_3010();
    drive(0, 0, 2'd2, 1, 0, 32'hDEAD_0001); step();
    chk("br_taken_pc_f", PC_F, 32'h0000_300C);
    chk("br_slot_instr", Instr_D, 32'hDEAD_0001);
    chk("br_slot_pc_d", PC_D, 32'h0000_3014);

    // Branch not taken
    beq_at_3010();
    drive(0, 0, 2'd2, 0, 0, 32'hDEAD_0002); step();
    chk("br_nt_pc_f", PC_F, 32'h0000_3018);

    // jal then jr
    drive(1, 0, 2'd0, 0, 0, 32'h0); step();
    drive(0, 0, 2'd0, 0, 0, JAL); step();
    chk("jal_pc8_d", PC8_D, 32'h0000_3008);
    drive(0, 0, 2'd1, 0, 0, 32'hDEAD_0003); step();
    chk("jal_pc_f", PC_F, 32'h0000_3100);
    drive(0, 0, 2'd0, 0, 0, JR); step();
    drive(0, 0, 2'd3, 0, 32'h0000_3100, 32'hDEAD_0004); step();
    chk("jr_pc_f", PC_F, 32'h0000_3100);

    // jr held by a two-cycle stall while its operand arrives
    drive(0, 0, 2'd0, 0, 0, JR); step();
    hold_pc = PC_F; hold_instr = Instr_D;
    drive(0, 1, 2'd3, 0, 32'h0, 32'h5555_0001); step();
    chk("stall1_pc_f", PC_F, hold_pc);
    chk("stall1_instr_d", Instr_D, hold_instr);
    drive(0, 1, 2'd3, 0, 32'h0000_3200, 32'h5555_0002); step();
    chk("stall2_pc_f", PC_F, hold_pc);
    chk("stall2_instr_d", Instr_D, hold_instr);
    drive(0, 0, 2'd3, 0, 32'h0000_3200, 32'h5555_0003); step();
    chk("stall_jr_pc_f", PC_F, 32'h0000_3200);

    // Reset beats stall and a taken branch
    drive(0, 0, 2'd0, 0, 0, BEQ); step();
    drive(1, 1, 2'd2, 1, 0, 32'h7777_0000); step();
    chk("rst_prio_pc_f", PC_F, 32'h0000_3000);
    chk("rst_prio_instr", Instr_D, 32'h0);

    // PC wrap-around
    drive(0, 0, 2'd3, 0, 32'hFFFF_FFFC, 32'h0); step();
    chk("wrap_pre_pc_f", PC_F, 32'hFFFF_FFFC);
    drive(0, 0, 2'd0, 0, 0, 32'h0); step();
    chk("wrap_pc_f", PC_F, 32'h0000_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom(), $urandom());
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
